// File: rtl/axi_burst_addr_gen.sv
// ============================================================================
// Module      : axi_burst_addr_gen
// Description : AXI read-burst beat address generator (FIXED/INCR/WRAP) with
//               last and per-beat error flags on a valid/ready beat stream.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_burst_addr_gen #(
    parameter int                 ADDR_W     = 32,
    parameter int                 LEN_W      = 8,
    parameter int                 MAX_SIZE   = 3,
    parameter logic [ADDR_W-1:0]  ADDR_LIMIT = 'hFF
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              ar_valid,
    output logic              ar_ready,
    input  logic [ADDR_W-1:0] ar_addr,
    input  logic [LEN_W-1:0]  ar_len,
    input  logic [2:0]        ar_size,
    input  logic [1:0]        ar_burst,
    output logic              beat_valid,
    input  logic              beat_ready,
    output logic [ADDR_W-1:0] beat_addr,
    output logic              beat_last,
    output logic              beat_err,
    output logic              busy
);

    localparam logic [2:0] c_MAX_SIZE    = 3'(MAX_SIZE);
    localparam logic [1:0] c_BURST_FIXED = 2'd0;
    localparam logic [1:0] c_BURST_WRAP  = 2'd2;
    localparam logic [1:0] c_BURST_RSVD  = 2'd3;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W-1:0]   r_inc;
    logic [ADDR_W-1:0]   r_mask;
    logic [LEN_W-1:0]    r_len;
    logic [LEN_W-1:0]    r_cnt;
    logic                r_berr;
    logic                r_valid;
    logic                r_busy;

    logic [ADDR_W-1:0]   w_inc;
    logic [ADDR_W-1:0]   w_bound;
    logic                w_misalign;
    logic                w_wrap_len_ok;
    logic                w_is_wrap;
    logic                w_berr;
    logic                w_last;
    logic [ADDR_W-1:0]   w_next_addr;

    assign w_inc         = ADDR_W'(1) << ar_size;
    assign w_bound       = (ADDR_W'(ar_len) + ADDR_W'(1)) << ar_size;
    assign w_misalign    = |(ar_addr & (w_inc - ADDR_W'(1)));
    assign w_is_wrap     = (ar_burst == c_BURST_WRAP);
    assign w_wrap_len_ok = (ar_len == LEN_W'(1)) || (ar_len == LEN_W'(3)) ||
                           (ar_len == LEN_W'(7)) || (ar_len == LEN_W'(15));
    assign w_berr        = (ar_size > c_MAX_SIZE) || (ar_burst == c_BURST_RSVD) ||
                           (w_is_wrap && (!w_wrap_len_ok || w_misalign));

    // One datapath covers all burst types: INCR uses an all-ones mask, WRAP
    // masks to the wrap window, FIXED and erroneous bursts use a zero step.
    assign w_next_addr   = (r_addr & ~r_mask) | ((r_addr + r_inc) & r_mask);
    assign w_last        = (r_cnt == r_len);

    assign ar_ready   = (r_state == S_IDLE);
    assign beat_valid = r_valid;
    assign busy       = r_busy;
    assign beat_addr  = r_addr;
    assign beat_last  = r_valid && w_last;
    assign beat_err   = r_valid && (r_berr || (r_addr > ADDR_LIMIT));

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_inc   <= '0;
            r_mask  <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_berr  <= 1'b0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (ar_valid) begin
                        r_state <= S_BURST;
                        r_addr  <= ar_addr;
                        r_len   <= ar_len;
                        r_cnt   <= '0;
                        r_berr  <= w_berr;
                        r_inc   <= (w_berr || (ar_burst == c_BURST_FIXED)) ? '0 : w_inc;
                        r_mask  <= (w_is_wrap && !w_berr) ? (w_bound - ADDR_W'(1)) : '1;
                        r_valid <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end
                S_BURST: begin
                    if (beat_ready) begin
                        if (w_last) begin
                            r_state <= S_IDLE;
                            r_valid <= 1'b0;
                            r_busy  <= 1'b0;
                        end else begin
                            r_addr <= w_next_addr;
                            r_cnt  <= r_cnt + LEN_W'(1);
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_axi_burst_addr_gen.sv
// ============================================================================
// Module      : tb_axi_burst_addr_gen
// Description : Self-checking bench: directed and random bursts against an
//               arithmetic reference model of the beat sequence.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axi_burst_addr_gen;

    localparam int ADDR_W = 32;
    localparam int LEN_W  = 8;

    logic              clk = 1'b0;
    logic              n_rst;
    logic              ar_valid;
    logic              ar_ready;
    logic [ADDR_W-1:0] ar_addr;
    logic [LEN_W-1:0]  ar_len;
    logic [2:0]        ar_size;
    logic [1:0]        ar_burst;
    logic              beat_valid;
    logic              beat_ready;
    logic [ADDR_W-1:0] beat_addr;
    logic              beat_last;
    logic              beat_err;
    logic              busy;

    int tests_run    = 0;
    int tests_failed = 0;

    axi_burst_addr_gen #(
        .ADDR_W     (ADDR_W),
        .LEN_W      (LEN_W),
        .MAX_SIZE   (3),
        .ADDR_LIMIT (32'hFF)
    ) u_dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .ar_valid   (ar_valid),
        .ar_ready   (ar_ready),
        .ar_addr    (ar_addr),
        .ar_len     (ar_len),
        .ar_size    (ar_size),
        .ar_burst   (ar_burst),
        .beat_valid (beat_valid),
        .beat_ready (beat_ready),
        .beat_addr  (beat_addr),
        .beat_last  (beat_last),
        .beat_err   (beat_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit ref_berr(input logic [31:0] a, input int len, input int size, input int burst);
        bit wrap_len_ok;
        wrap_len_ok = (len == 1) || (len == 3) || (len == 7) || (len == 15);
        if (size > 3 || burst == 3) return 1'b1;
        if (burst == 2 && (!wrap_len_ok || (a % (32'd1 << size)) != 0)) return 1'b1;
        return 1'b0;
    endfunction

    // Beat i of the burst, computed directly from the start address.
    function automatic logic [31:0] ref_addr(input logic [31:0] a, input int len, input int size,
                                             input int burst, input int i);
        logic [31:0] inc, bound, base;
        if (ref_berr(a, len, size, burst) || burst == 0) return a;
        inc = 32'd1 << size;
        if (burst == 1) return a + 32'(i) * inc;
        bound = 32'(len + 1) * inc;
        base  = a - (a % bound);
        return base + ((a - base + 32'(i) * inc) % bound);
    endfunction

    task automatic run_burst(input logic [31:0] a, input int len, input int size, input int burst,
                             input int stall_pct, input int rst_at);
        int          i;
        int          cyc;
        logic [31:0] ea;
        bit          eerr;
        @(negedge clk);
        check("ar_ready_idle", ar_ready, 1);
        ar_valid = 1'b1;
        ar_addr  = a;
        ar_len   = LEN_W'(len);
        ar_size  = 3'(size);
        ar_burst = 2'(burst);
        @(negedge clk);
        ar_valid = 1'b0;
        check("first_beat_latency", beat_valid, 1);
        check("ar_ready_busy", ar_ready, 0);
        check("busy", busy, 1);
        i   = 0;
        cyc = 0;
        while (i <= len && cyc < 2000) begin
            if (!beat_valid) begin
                check("beat_valid_dropped", beat_valid, 1);
                break;
            end
            ea   = ref_addr(a, len, size, burst, i);
            eerr = ref_berr(a, len, size, burst) || (ea > 32'hFF);
            check("beat_addr", beat_addr, ea);
            check("beat_last", beat_last, (i == len));
            check("beat_err", beat_err, eerr);
            if (rst_at == i) begin
                n_rst = 1'b0;
                #1;
                check("rst_beat_valid", beat_valid, 0);
                check("rst_ar_ready", ar_ready, 1);
                check("rst_busy", busy, 0);
                check("rst_beat_addr", beat_addr, 0);
                beat_ready = 1'b0;
                @(negedge clk);
                n_rst = 1'b1;
                return;
            end
            beat_ready = ($urandom_range(99) >= 32'(stall_pct));
            @(negedge clk);
            if (beat_ready) i++;
            cyc++;
        end
        check("handshake_count", i, len + 1);
        beat_ready = 1'b0;
        check("ar_ready_after", ar_ready, 1);
        check("beat_valid_after", beat_valid, 0);
        check("busy_after", busy, 0);
    endtask

    initial begin
        int len, size, burst;
        logic [31:0] a;
        n_rst      = 1'b1;
        ar_valid   = 1'b0;
        ar_addr    = '0;
        ar_len     = '0;
        ar_size    = '0;
        ar_burst   = '0;
        beat_ready = 1'b0;
        #1 n_rst = 1'b0;
        #1;
        check("reset_ar_ready", ar_ready, 1);
        check("reset_beat_valid", beat_valid, 0);
        check("reset_beat_addr", beat_addr, 0);
        check("reset_beat_last", beat_last, 0);
        check("reset_beat_err", beat_err, 0);
        check("reset_busy", busy, 0);
        repeat (2) @(negedge clk);
        n_rst = 1'b1;

        run_burst(32'h10, 3, 2, 1, 0, -1);
        run_burst(32'h18, 3, 2, 2, 0, -1);
        run_burst(32'h18, 2, 2, 2, 0, -1);
        run_burst(32'h40, 2, 0, 0, 0, -1);
        run_burst(32'hF0, 3, 3, 1, 0, -1);
        run_burst(32'h20, 1, 4, 1, 0, -1);
        run_burst(32'h30, 2, 1, 3, 0, -1);
        run_burst(32'h1A, 3, 2, 2, 0, -1);
        run_burst(32'h00, 7, 2, 1, 50, -1);
        run_burst(32'h60, 7, 2, 1, 40, 3);
        run_burst(32'h80, 3, 2, 1, 30, -1);
        run_burst(32'hFFFF_FFF8, 1, 3, 1, 0, -1);

        for (int t = 0; t < 60; t++) begin
            burst = int'($urandom_range(3));
            size  = int'($urandom_range(4));
            if (burst == 2 && $urandom_range(3) != 0) begin
                len = (2 << $urandom_range(3)) - 1;
                a   = 32'($urandom_range(32'h1FF)) & ~((32'd1 << size) - 32'd1);
            end else begin
                len = int'($urandom_range(15));
                a   = 32'($urandom_range(32'h1FF));
            end
            run_burst(a, len, size, burst, int'($urandom_range(60)), -1);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

`default_nettype wire
